// File: rtl/fir_xifu_pkg.sv
// Shared types and constants for the FIR CV-XIF interface unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package fir_xifu_pkg;

  localparam int X_ID_WIDTH = 4;
  localparam int X_ID_MAX   = (1 << X_ID_WIDTH) - 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } fir_xifu_commit_state_e;

  // One beat on the CV-XIF commit channel.
  typedef struct packed {
    logic                  valid;
    logic [X_ID_WIDTH-1:0] id;
    logic                  kill;
  } fir_xifu_commit_t;

endpackage

// File: rtl/fir_xifu_commit_gen_if.sv
// Bundles the issue-observe, resolve and commit signals of the commit generator.
// Latency: n/a (wiring only).
// Backpressure: issue_stall_o and ctrl_ready_o flow from the generator (slave) to the core (master).
interface fir_xifu_commit_gen_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int DEPTH      = 4
);

  logic                    issue_valid_i;
  logic                    issue_ready_i;
  logic                    issue_accept_i;
  logic [X_ID_WIDTH-1:0]   issue_id_i;
  logic                    issue_stall_o;
  logic                    ctrl_valid_i;
  logic                    ctrl_kill_i;
  logic                    ctrl_ready_o;
  logic                    flush_i;
  logic                    commit_valid_o;
  logic [X_ID_WIDTH-1:0]   commit_id_o;
  logic                    commit_kill_o;
  logic [$clog2(DEPTH):0]  outstanding_o;
  logic                    err_o;

  modport master (
    output issue_valid_i, issue_ready_i, issue_accept_i, issue_id_i,
    output ctrl_valid_i, ctrl_kill_i, flush_i,
    input  issue_stall_o, ctrl_ready_o, commit_valid_o, commit_id_o,
    input  commit_kill_o, outstanding_o, err_o
  );

  modport slave (
    input  issue_valid_i, issue_ready_i, issue_accept_i, issue_id_i,
    input  ctrl_valid_i, ctrl_kill_i, flush_i,
    output issue_stall_o, ctrl_ready_o, commit_valid_o, commit_id_o,
    output commit_kill_o, outstanding_o, err_o
  );

endinterface

// File: rtl/fir_xifu_id_fifo.sv
// In-order FIFO of instruction IDs with occupancy count.
// Latency: head visible the cycle after the push into an empty FIFO.
// Backpressure: push ignored when full, pop ignored when empty; caller stalls on full.
module fir_xifu_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage needs no reset: only entries below count are ever read as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fir_xifu_commit_gen.sv
// Core-side CV-XIF commit generator: one commit/kill per accepted offload ID, in issue order.
// Latency: commit pulse 1 cycle after the pop (ctrl handshake, flush drain or auto-kill).
// Backpressure: issue_stall_o on full or while flushing; ctrl_ready_o low when empty/flushing.
// Optional macro FIR_XIFU_COMMIT_TIMEOUT_EN: auto-kill the head after TIMEOUT idle cycles.
module fir_xifu_commit_gen
  import fir_xifu_pkg::*;
#(
  parameter int X_ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 64
) (
  input logic                  clk_i,
  input logic                  rst_i,
  fir_xifu_commit_gen_if.slave bus
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int NID = 1 << X_ID_WIDTH;

  fir_xifu_commit_state_e state_q, state_d;
  fir_xifu_commit_t       commit_q, commit_d;

  logic [NID-1:0]        bitmap_q;
  logic                  err_q;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic [X_ID_WIDTH-1:0] head_id;
  logic                  stall;
  logic                  record;
  logic                  dup;
  logic                  push;
  logic                  pop;
  logic                  pop_kill;
  logic                  ctrl_ready;
  logic                  timeout_fire;

  assign stall  = full | (state_q == FLUSH);
  assign record = bus.issue_valid_i & bus.issue_ready_i & bus.issue_accept_i & ~stall;
  // An ID already in flight must never be queued twice; the duplicate is dropped and flagged.
  assign dup    = record & bitmap_q[bus.issue_id_i];
  assign push   = record & ~dup;

  fir_xifu_id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (X_ID_WIDTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .pop       (pop),
    .push_data (bus.issue_id_i),
    .head_data (head_id),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

`ifdef FIR_XIFU_COMMIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] age_q;

  // Flush takes precedence over an auto-kill landing in the same cycle.
  assign timeout_fire = (state_q == IDLE) & ~empty & ~bus.flush_i & (age_q == TW'(TIMEOUT - 1));

  // Age of the current head: restarts on every pop and on the first record into an empty FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      age_q <= '0;
    end else if (pop | (push & empty)) begin
      age_q <= '0;
    end else if ((state_q == IDLE) & ~empty) begin
      age_q <= age_q + TW'(1);
    end
  end
`else
  // TIMEOUT only matters when auto-kill is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_fire   = 1'b0;
`endif

  // Next state, pop decision and ctrl_ready.
  always_comb begin
    state_d    = state_q;
    ctrl_ready = 1'b0;
    pop        = 1'b0;
    pop_kill   = 1'b0;
    case (state_q)
      IDLE: begin
        ctrl_ready = ~empty & ~bus.flush_i & ~timeout_fire;
        if (timeout_fire) begin
          pop      = 1'b1;
          pop_kill = 1'b1;
        end else if (bus.ctrl_valid_i & ctrl_ready) begin
          pop      = 1'b1;
          pop_kill = bus.ctrl_kill_i;
        end
        // A record in the flush cycle joins the drain, so an empty FIFO plus a push still flushes.
        if (bus.flush_i & (~empty | push)) state_d = FLUSH;
      end
      FLUSH: begin
        pop      = 1'b1;
        pop_kill = 1'b1;
        if (count == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit beat registered from the pop decision; id/kill are zeroed when no beat is emitted.
  always_comb begin
    commit_d       = '0;
    commit_d.valid = pop;
    if (pop) begin
      commit_d.id   = head_id;
      commit_d.kill = pop_kill;
    end
  end

  // State, commit output and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      commit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      commit_q <= commit_d;
      if (dup | (bus.ctrl_valid_i & empty) | timeout_fire) err_q <= 1'b1;
    end
  end

  // Outstanding-ID bitmap mirrors FIFO contents for duplicate detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bitmap_q <= '0;
    end else begin
      if (pop)  bitmap_q[head_id]        <= 1'b0;
      if (push) bitmap_q[bus.issue_id_i] <= 1'b1;
    end
  end

  assign bus.issue_stall_o  = stall;
  assign bus.ctrl_ready_o   = ctrl_ready;
  assign bus.commit_valid_o = commit_q.valid;
  assign bus.commit_id_o    = commit_q.id;
  assign bus.commit_kill_o  = commit_q.kill;
  assign bus.outstanding_o  = count;
  assign bus.err_o          = err_q;

endmodule

// File: tb/tb_fir_xifu_commit_gen.sv
// Bench for fir_xifu_commit_gen: directed scenarios plus randomized traffic against a queue model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fir_xifu_commit_gen;

  localparam int XW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef FIR_XIFU_COMMIT_TIMEOUT_EN
  localparam int TIMEOUT = 8;
  localparam bit TO_EN   = 1'b1;
`else
  localparam int TIMEOUT = 64;
  localparam bit TO_EN   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_xifu_commit_gen_if #(.X_ID_WIDTH(XW), .DEPTH(DEPTH)) bus ();

  fir_xifu_commit_gen #(.X_ID_WIDTH(XW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of outstanding IDs in issue order plus a draining flag.
  int q[$];
  bit m_flush, m_err, c_v, c_k, m_stall, m_ready, m_tfire;
  int c_id, age;

  task automatic set_idle();
    bus.issue_valid_i  = 1'b0;
    bus.issue_ready_i  = 1'b0;
    bus.issue_accept_i = 1'b0;
    bus.issue_id_i     = '0;
    bus.ctrl_valid_i   = 1'b0;
    bus.ctrl_kill_i    = 1'b0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic set_issue(input int id);
    bus.issue_valid_i  = 1'b1;
    bus.issue_ready_i  = 1'b1;
    bus.issue_accept_i = 1'b1;
    bus.issue_id_i     = XW'(id);
  endtask

  // Go to the falling edge and derive the model's expected combinational outputs.
  task automatic sample();
    @(negedge clk);
    m_stall = (q.size() == DEPTH) || m_flush;
    m_tfire = TO_EN && !m_flush && q.size() > 0 && !bus.flush_i && age == TIMEOUT - 1;
    m_ready = !m_flush && q.size() > 0 && !bus.flush_i && !m_tfire;
  endtask

  // Apply the clock edge to the model, then advance the DUT past it.
  task automatic advance();
    bit rec, dup, pop, kill;
    int n0;
    n0 = q.size();
    if (rst) begin
      q.delete();
      m_flush = 0; m_err = 0; c_v = 0; c_id = 0; c_k = 0; age = 0;
    end else begin
      rec = bus.issue_valid_i && bus.issue_ready_i && bus.issue_accept_i && !m_stall;
      dup = 0;
      if (rec) foreach (q[i]) if (q[i] == int'(bus.issue_id_i)) dup = 1;
      pop = 0; kill = 0;
      if (m_flush || m_tfire) begin
        pop = 1; kill = 1;
      end else if (bus.ctrl_valid_i && m_ready) begin
        pop = 1; kill = bus.ctrl_kill_i;
      end
      if ((bus.ctrl_valid_i && n0 == 0) || dup || m_tfire) m_err = 1;
      c_v = pop; c_k = kill; c_id = 0;
      if (pop) c_id = q.pop_front();
      if (rec && !dup) q.push_back(int'(bus.issue_id_i));
      if (pop || (rec && !dup && n0 == 0)) age = 0;
      else if (!m_flush && n0 > 0) age++;
      m_flush = (m_flush || bus.flush_i) && q.size() > 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; set_idle(); sample(); advance(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_idle();
    sample(); advance(); sample(); advance();
    rst = 1'b0;
    sample();
    checks++; if (bus.commit_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cvalid got %b exp 0", bus.commit_valid_o); end
    checks++; if (bus.commit_id_o !== 4'd0) begin errors++; $display("FAIL reset_cid got %0d exp 0", bus.commit_id_o); end
    checks++; if (bus.commit_kill_o !== 1'b0) begin errors++; $display("FAIL reset_ckill got %b exp 0", bus.commit_kill_o); end
    checks++; if (bus.outstanding_o !== 3'd0) begin errors++; $display("FAIL reset_out got %0d exp 0", bus.outstanding_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
    checks++; if (bus.ctrl_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.ctrl_ready_o); end
    checks++; if (bus.issue_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.issue_stall_o); end
    advance();
  endtask

  task automatic test_commit_order();
    int ids[3] = '{3, 5, 7};
    bit kills[3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    foreach (ids[i]) begin set_issue(ids[i]); sample(); advance(); end
    // Handshake without accept must not record.
    bus.issue_accept_i = 1'b0; bus.issue_id_i = 4'd9; sample(); advance();
    set_idle(); bus.ctrl_valid_i = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      bus.ctrl_valid_i = (k < 3); bus.ctrl_kill_i = (k < 3) ? kills[k] : 1'b0;
      sample();
      if (k == 0) begin
        checks++; if (bus.outstanding_o !== 3'd3) begin errors++; $display("FAIL order_out0 got %0d exp 3", bus.outstanding_o); end
        checks++; if (bus.ctrl_ready_o !== 1'b1) begin errors++; $display("FAIL order_ready got %b exp 1", bus.ctrl_ready_o); end
      end
      checks++;
      if (k >= 1 && k <= 3) begin
        if (bus.commit_valid_o !== 1'b1 || bus.commit_id_o !== XW'(ids[k-1]) || bus.commit_kill_o !== kills[k-1]) begin
          errors++; $display("FAIL order_commit%0d got v=%b id=%0d k=%b exp v=1 id=%0d k=%b", k, bus.commit_valid_o, bus.commit_id_o, bus.commit_kill_o, ids[k-1], kills[k-1]);
        end
      end else if (bus.commit_valid_o !== 1'b0) begin
        errors++; $display("FAIL order_idle%0d got v=%b exp 0", k, bus.commit_valid_o);
      end
      advance();
    end
    checks++; if (bus.outstanding_o !== 3'd0) begin errors++; $display("FAIL order_out_end got %0d exp 0", bus.outstanding_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 10; i < 14; i++) begin set_issue(i); sample(); advance(); end
    set_issue(14); sample();
    checks++; if (bus.issue_stall_o !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", bus.issue_stall_o); end
    checks++; if (bus.outstanding_o !== 3'd4) begin errors++; $display("FAIL full_out got %0d exp 4", bus.outstanding_o); end
    advance();
    set_idle(); bus.ctrl_valid_i = 1'b1; sample();
    checks++; if (bus.outstanding_o !== 3'd4) begin errors++; $display("FAIL full_noRec got %0d exp 4", bus.outstanding_o); end
    advance();
    set_issue(14); sample();
    checks++; if (bus.issue_stall_o !== 1'b0) begin errors++; $display("FAIL full_unstall got %b exp 0", bus.issue_stall_o); end
    advance();
    set_idle(); sample();
    checks++; if (bus.outstanding_o !== 3'd3) begin errors++; $display("FAIL full_pushpop got %0d exp 3", bus.outstanding_o); end
    checks++; if (bus.commit_valid_o !== 1'b1 || bus.commit_id_o !== 4'd11) begin errors++; $display("FAIL full_commit got v=%b id=%0d exp v=1 id=11", bus.commit_valid_o, bus.commit_id_o); end
    advance();
  endtask

  task automatic test_flush();
    int exp_ids[3] = '{1, 2, 9};
    do_reset();
    set_issue(1); sample(); advance();
    set_issue(2); sample(); advance();
    set_issue(9); bus.flush_i = 1'b1; sample();
    checks++; if (bus.ctrl_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready0 got %b exp 0", bus.ctrl_ready_o); end
    advance();
    set_idle(); bus.ctrl_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++; if (bus.ctrl_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready%0d got %b exp 0", k + 1, bus.ctrl_ready_o); end
      if (k < 3) begin
        checks++; if (bus.issue_stall_o !== 1'b1) begin errors++; $display("FAIL flush_stall%0d got %b exp 1", k, bus.issue_stall_o); end
      end
      if (k >= 1 && k <= 3) begin
        checks++;
        if (bus.commit_valid_o !== 1'b1 || bus.commit_id_o !== XW'(exp_ids[k-1]) || bus.commit_kill_o !== 1'b1) begin
          errors++; $display("FAIL flush_kill%0d got v=%b id=%0d k=%b exp v=1 id=%0d k=1", k, bus.commit_valid_o, bus.commit_id_o, bus.commit_kill_o, exp_ids[k-1]);
        end
      end
      if (k == 3) begin
        checks++; if (bus.issue_stall_o !== 1'b0 || bus.outstanding_o !== 3'd0) begin errors++; $display("FAIL flush_done got stall=%b out=%0d exp stall=0 out=0", bus.issue_stall_o, bus.outstanding_o); end
      end
      if (k == 4) begin
        checks++; if (bus.commit_valid_o !== 1'b0) begin errors++; $display("FAIL flush_after got v=%b exp 0", bus.commit_valid_o); end
      end
      bus.ctrl_valid_i = 1'b0;
      advance();
    end
  endtask

  task automatic test_dup_and_empty();
    do_reset();
    set_issue(6); sample(); advance();
    set_issue(6); sample(); advance();
    set_idle(); bus.ctrl_valid_i = 1'b1; sample();
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL dup_err got %b exp 1", bus.err_o); end
    checks++; if (bus.outstanding_o !== 3'd1) begin errors++; $display("FAIL dup_out got %0d exp 1", bus.outstanding_o); end
    advance();
    sample();
    checks++; if (bus.commit_valid_o !== 1'b1 || bus.commit_id_o !== 4'd6 || bus.commit_kill_o !== 1'b0) begin errors++; $display("FAIL dup_commit got v=%b id=%0d k=%b exp v=1 id=6 k=0", bus.commit_valid_o, bus.commit_id_o, bus.commit_kill_o); end
    advance();
    bus.ctrl_valid_i = 1'b0; sample();
    checks++; if (bus.commit_valid_o !== 1'b0) begin errors++; $display("FAIL empty_nocommit got v=%b exp 0", bus.commit_valid_o); end
    advance();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    for (int i = 4; i < 7; i++) begin set_issue(i); sample(); advance(); end
    set_idle(); bus.flush_i = 1'b1; sample(); advance();
    bus.flush_i = 1'b0; sample(); advance();
    sample(); advance();
    rst = 1'b1; sample();
    checks++; if (bus.commit_valid_o !== 1'b1 || bus.commit_id_o !== 4'd5 || bus.commit_kill_o !== 1'b1) begin errors++; $display("FAIL rstfl_kill2 got v=%b id=%0d k=%b exp v=1 id=5 k=1", bus.commit_valid_o, bus.commit_id_o, bus.commit_kill_o); end
    advance();
    rst = 1'b0; set_issue(2); sample();
    checks++;
    if (bus.commit_valid_o !== 1'b0 || bus.commit_id_o !== 4'd0 || bus.commit_kill_o !== 1'b0 || bus.outstanding_o !== 3'd0 ||
        bus.err_o !== 1'b0 || bus.ctrl_ready_o !== 1'b0 || bus.issue_stall_o !== 1'b0) begin
      errors++; $display("FAIL rstfl_zero got v=%b id=%0d k=%b out=%0d err=%b rdy=%b stall=%b exp all 0", bus.commit_valid_o, bus.commit_id_o, bus.commit_kill_o, bus.outstanding_o, bus.err_o, bus.ctrl_ready_o, bus.issue_stall_o);
    end
    advance();
    set_idle(); bus.ctrl_valid_i = 1'b1; sample(); advance();
    bus.ctrl_valid_i = 1'b0; sample();
    checks++; if (bus.commit_valid_o !== 1'b1 || bus.commit_id_o !== 4'd2 || bus.commit_kill_o !== 1'b0) begin errors++; $display("FAIL rstfl_commit got v=%b id=%0d k=%b exp v=1 id=2 k=0", bus.commit_valid_o, bus.commit_id_o, bus.commit_kill_o); end
    advance();
  endtask

`ifdef FIR_XIFU_COMMIT_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    set_issue(1); sample(); advance();
    set_idle();
    for (int k = 1; k <= 9; k++) begin
      sample();
      checks++; if (bus.commit_valid_o !== (k == 9)) begin errors++; $display("FAIL timeout_v%0d got %b exp %b", k, bus.commit_valid_o, (k == 9)); end
      if (k == 8) begin
        checks++; if (bus.ctrl_ready_o !== 1'b0) begin errors++; $display("FAIL timeout_ready got %b exp 0", bus.ctrl_ready_o); end
      end
      if (k == 9) begin
        checks++; if (bus.commit_id_o !== 4'd1 || bus.commit_kill_o !== 1'b1 || bus.err_o !== 1'b1) begin errors++; $display("FAIL timeout_kill got id=%0d k=%b err=%b exp id=1 k=1 err=1", bus.commit_id_o, bus.commit_kill_o, bus.err_o); end
      end
      advance();
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst                = ($urandom_range(63, 0) == 0);
      bus.issue_valid_i  = ($urandom_range(3, 0) != 0);
      bus.issue_ready_i  = ($urandom_range(3, 0) != 0);
      bus.issue_accept_i = ($urandom_range(3, 0) != 0);
      bus.issue_id_i     = XW'($urandom_range(fir_xifu_pkg::X_ID_MAX, 0));
      bus.ctrl_valid_i   = ($urandom_range(2, 0) == 0);
      bus.ctrl_kill_i    = $urandom_range(1, 0) != 0;
      bus.flush_i        = ($urandom_range(19, 0) == 0);
      sample();
      checks++; if (bus.issue_stall_o !== m_stall) begin errors++; $display("FAIL rnd_stall n=%0d got %b exp %b", n, bus.issue_stall_o, m_stall); end
      checks++; if (bus.ctrl_ready_o !== m_ready) begin errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, bus.ctrl_ready_o, m_ready); end
      checks++; if (bus.outstanding_o !== CW'(q.size())) begin errors++; $display("FAIL rnd_out n=%0d got %0d exp %0d", n, bus.outstanding_o, q.size()); end
      checks++; if (bus.err_o !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %b exp %b", n, bus.err_o, m_err); end
      checks++; if (bus.commit_valid_o !== c_v) begin errors++; $display("FAIL rnd_cvalid n=%0d got %b exp %b", n, bus.commit_valid_o, c_v); end
      if (c_v) begin
        checks++; if (bus.commit_id_o !== XW'(c_id) || bus.commit_kill_o !== c_k) begin errors++; $display("FAIL rnd_commit n=%0d got id=%0d k=%b exp id=%0d k=%b", n, bus.commit_id_o, bus.commit_kill_o, c_id, c_k); end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_commit_order();
    test_full();
    test_flush();
    test_dup_and_empty();
    test_reset_mid_flush();
`ifdef FIR_XIFU_COMMIT_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
